// File: rtl/mccu_period_ctrl_if.sv
// Signal bundle between the register wrapper / MCCU side and the period controller.
// master drives the controls and observes the status; slave is the controller.
interface mccu_period_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                                 start_i;
  logic                                 stop_i;
  logic [DATA_WIDTH-1:0]                period_i;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]   reload_quota_i;
  logic [N_CORES-1:0]                   irq_i;
  logic [N_CORES-1:0]                   irq_ack_i;
  logic                                 mccu_enable_o;
  logic [N_CORES-1:0]                   update_quota_o;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]   quota_o;
  logic [N_CORES-1:0]                   overrun_o;
  logic [N_CORES-1:0]                   stall_o;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]    overrun_cnt_o;
  logic [DATA_WIDTH-1:0]                period_cnt_o;
  logic                                 irq_o;
  logic [1:0]                           state_o;

  modport master (
    output start_i, stop_i, period_i, reload_quota_i, irq_i, irq_ack_i,
    input  mccu_enable_o, update_quota_o, quota_o, overrun_o, stall_o,
           overrun_cnt_o, period_cnt_o, irq_o, state_o
  );

  modport slave (
    input  start_i, stop_i, period_i, reload_quota_i, irq_i, irq_ack_i,
    output mccu_enable_o, update_quota_o, quota_o, overrun_o, stall_o,
           overrun_cnt_o, period_cnt_o, irq_o, state_o
  );
endinterface

// File: rtl/mccu_period_ctrl.sv
// Period controller for the MCCU: replenishes per-core quotas every period and
// tracks quota interruptions as sticky overruns, per-period stalls and counters.
module mccu_period_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  mccu_period_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                             state_q, state_d;
  logic [DATA_WIDTH-1:0]              timer_q, timer_d;
  logic [DATA_WIDTH-1:0]              period_cnt_q, period_cnt_d;
  logic [DATA_WIDTH-1:0]              reload_val;
  logic [N_CORES-1:0][DATA_WIDTH-1:0] quota_q, quota_d;
  logic [N_CORES-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_CORES-1:0]                 update_q, update_d;
  logic [N_CORES-1:0]                 overrun_q, overrun_d;
  logic [N_CORES-1:0]                 stall_q, stall_d;
  logic [N_CORES-1:0]                 seen_q, seen_d;
  logic [N_CORES-1:0]                 irq_en;
  logic                               enable_q, enable_d;
  logic                               irq_q, irq_d;
  logic                               boundary;

  // One-shot mode (period 0) parks the timer at 0 so it never reaches a boundary.
  assign reload_val = (bus.period_i == '0) ? '0 : bus.period_i - DATA_WIDTH'(1);
  assign boundary   = (state_q == RUN) && (timer_q == '0) &&
                      (bus.period_i != '0) && !bus.stop_i;
  assign irq_en     = bus.irq_i & {N_CORES{enable_q}};

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (bus.stop_i) state_d = IDLE;
  end

  // Output / datapath next values
  always_comb begin
    timer_d      = timer_q;
    period_cnt_d = period_cnt_q;
    quota_d      = quota_q;
    update_d     = '0;
    enable_d     = (state_d == RUN);
    overrun_d    = (overrun_q & ~bus.irq_ack_i) | irq_en;
    stall_d      = stall_q | irq_en;
    seen_d       = seen_q | irq_en;
    cnt_d        = cnt_q;

    // Counting uses the old seen bits, so a boundary-cycle irq credits the ending period.
    for (int unsigned c = 0; c < N_CORES; c++) begin
      if (irq_en[c] && !seen_q[c] && (cnt_q[c] != '1)) begin
        cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
      end
    end

    if (state_q == IDLE && state_d == LOAD) begin
      update_d = '1;
      quota_d  = bus.reload_quota_i;
      timer_d  = reload_val;
      stall_d  = '0;
      seen_d   = '0;
    end else if (boundary) begin
      update_d     = '1;
      quota_d      = bus.reload_quota_i;
      timer_d      = reload_val;
      period_cnt_d = period_cnt_q + DATA_WIDTH'(1);
      stall_d      = '0;
      seen_d       = '0;
    end else if (state_q == RUN && timer_q != '0) begin
      timer_d = timer_q - DATA_WIDTH'(1);
    end

    irq_d = |overrun_d;
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q      <= '0;
      period_cnt_q <= '0;
      quota_q      <= '0;
      cnt_q        <= '0;
      update_q     <= '0;
      overrun_q    <= '0;
      stall_q      <= '0;
      seen_q       <= '0;
      enable_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      period_cnt_q <= period_cnt_d;
      quota_q      <= quota_d;
      cnt_q        <= cnt_d;
      update_q     <= update_d;
      overrun_q    <= overrun_d;
      stall_q      <= stall_d;
      seen_q       <= seen_d;
      enable_q     <= enable_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.state_o        = state_q;
  assign bus.mccu_enable_o  = enable_q;
  assign bus.update_quota_o = update_q;
  assign bus.quota_o        = quota_q;
  assign bus.overrun_o      = overrun_q;
  assign bus.stall_o        = stall_q;
  assign bus.overrun_cnt_o  = cnt_q;
  assign bus.period_cnt_o   = period_cnt_q;
  assign bus.irq_o          = irq_q;

endmodule

// File: tb/tb_mccu_period_ctrl.sv
// Bench for mccu_period_ctrl: a cycle model queues the expected outputs for every
// clock edge, and each queued entry is compared once the DUT has updated.
module tb_mccu_period_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mccu_period_ctrl_if #(.DATA_WIDTH(DW), .N_CORES(NC), .CNT_WIDTH(CW)) bus ();

  mccu_period_ctrl #(.DATA_WIDTH(DW), .N_CORES(NC), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]                 state;
    logic                       en;
    logic [NC-1:0]              upd;
    logic [NC-1:0][DW-1:0]      quota;
    logic [NC-1:0]              ovr;
    logic [NC-1:0]              stall;
    logic [NC-1:0][CW-1:0]      cnt;
    logic [DW-1:0]              pcnt;
    logic                       irq;
  } snap_t;

  int          n_checks = 0;
  int          n_errors = 0;
  snap_t       m;
  logic [DW-1:0] m_timer;
  logic [NC-1:0] m_seen;
  snap_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_snap(input snap_t e);
    check("state",   64'(bus.state_o),        64'(e.state));
    check("enable",  64'(bus.mccu_enable_o),  64'(e.en));
    check("update",  64'(bus.update_quota_o), 64'(e.upd));
    for (int c = 0; c < NC; c++)
      check($sformatf("quota%0d", c), 64'(bus.quota_o[c]), 64'(e.quota[c]));
    check("overrun", 64'(bus.overrun_o),      64'(e.ovr));
    check("stall",   64'(bus.stall_o),        64'(e.stall));
    check("ovr_cnt", 64'(bus.overrun_cnt_o),  64'(e.cnt));
    check("pcnt",    64'(bus.period_cnt_o),   64'(e.pcnt));
    check("irq",     64'(bus.irq_o),          64'(e.irq));
  endtask

  task automatic model_reset();
    m = '{default: '0};
    m_timer = '0;
    m_seen = '0;
    exp_q.delete();
  endtask

  // Expected outputs after the coming clock edge, given the current inputs.
  task automatic model_edge();
    snap_t n;
    logic [NC-1:0] ien;
    logic [NC-1:0] nseen;
    n = m;
    ien = bus.irq_i & {NC{m.en}};
    n.upd = '0;
    for (int c = 0; c < NC; c++)
      if (ien[c] && !m_seen[c] && m.cnt[c] != 2'b11) n.cnt[c] = m.cnt[c] + 2'd1;
    n.ovr   = (m.ovr & ~bus.irq_ack_i) | ien;
    n.stall = m.stall | ien;
    nseen   = m_seen | ien;
    if (bus.stop_i) begin
      n.state = 2'd0;
    end else if (m.state == 2'd0) begin
      if (bus.start_i) begin
        n.state = 2'd1;
        n.upd   = '1;
        n.quota = bus.reload_quota_i;
        m_timer = (bus.period_i == 0) ? '0 : bus.period_i - 32'd1;
        n.stall = '0;
        nseen   = '0;
      end
    end else if (m.state == 2'd1) begin
      n.state = 2'd2;
    end else begin
      if (m_timer == 0 && bus.period_i != 0) begin
        n.upd   = '1;
        n.quota = bus.reload_quota_i;
        m_timer = bus.period_i - 32'd1;
        n.pcnt  = m.pcnt + 32'd1;
        n.stall = '0;
        nseen   = '0;
      end else if (m_timer != 0) begin
        m_timer = m_timer - 32'd1;
      end
    end
    n.en  = (n.state == 2'd2);
    n.irq = |n.ovr;
    m      = n;
    m_seen = nseen;
    exp_q.push_back(n);
  endtask

  task automatic step(input int cycles);
    snap_t e;
    for (int i = 0; i < cycles; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        compare_snap(e);
      end
    end
  endtask

  initial begin
    rstn               = 1'b0;
    bus.start_i        = 1'b0;
    bus.stop_i         = 1'b0;
    bus.period_i       = '0;
    bus.reload_quota_i = '0;
    bus.irq_i          = '0;
    bus.irq_ack_i      = '0;
    model_reset();
    #1;
    compare_snap(m);
    @(negedge clk);
    rstn = 1'b1;
    step(2);

    // Periodic replenish, P=10
    bus.period_i = 32'd10;
    for (int c = 0; c < NC; c++) bus.reload_quota_i[c] = 32'((c + 1) * 100);
    bus.start_i = 1'b1; step(1); bus.start_i = 1'b0;
    check("load_update", 64'(bus.update_quota_o), 64'hF);
    check("load_quota2", 64'(bus.quota_o[2]), 64'd300);
    check("load_enable", 64'(bus.mccu_enable_o), 64'd0);
    step(1);
    check("run_enable", 64'(bus.mccu_enable_o), 64'd1);
    bus.reload_quota_i[0] = 32'd111;
    step(50);
    check("pcnt_after50", 64'(bus.period_cnt_o), 64'd5);

    // Core 1 overruns for three cycles inside one period
    bus.irq_i[1] = 1'b1; step(3); bus.irq_i[1] = 1'b0;
    check("ovr1_set",   64'(bus.overrun_o[1]), 64'd1);
    check("stall1_set", 64'(bus.stall_o[1]), 64'd1);
    check("cnt1_once",  64'(bus.overrun_cnt_o[1]), 64'd1);
    step(7);
    check("stall1_clr", 64'(bus.stall_o[1]), 64'd0);
    check("ovr1_stick", 64'(bus.overrun_o[1]), 64'd1);
    bus.irq_ack_i[1] = 1'b1; step(1); bus.irq_ack_i[1] = 1'b0;
    check("ovr1_acked", 64'(bus.overrun_o[1]), 64'd0);

    // Ack and irq together on core 2: set wins
    bus.irq_i[2] = 1'b1; step(1);
    bus.irq_ack_i[2] = 1'b1; step(1);
    bus.irq_i[2] = 1'b0; bus.irq_ack_i[2] = 1'b0;
    check("ovr2_setwins", 64'(bus.overrun_o[2]), 64'd1);
    bus.stop_i = 1'b1; step(1); bus.stop_i = 1'b0;
    check("stop_enable", 64'(bus.mccu_enable_o), 64'd0);
    bus.irq_ack_i[2] = 1'b1; step(1); bus.irq_ack_i[2] = 1'b0;
    bus.irq_i[2] = 1'b1; step(3); bus.irq_i[2] = 1'b0;
    check("idle_irq_ovr", 64'(bus.overrun_o[2]), 64'd0);
    check("idle_irq_cnt", 64'(bus.overrun_cnt_o[2]), 64'd1);

    // One-shot budget, P=0
    bus.period_i = 32'd0;
    bus.start_i = 1'b1; step(1); bus.start_i = 1'b0;
    step(31);
    check("oneshot_pcnt", 64'(bus.period_cnt_o), 64'd6);
    check("oneshot_upd",  64'(bus.update_quota_o), 64'd0);

    // P=1: replenish every RUN cycle
    bus.stop_i = 1'b1; step(1); bus.stop_i = 1'b0;
    bus.period_i = 32'd1;
    bus.start_i = 1'b1; step(1); bus.start_i = 1'b0;
    step(2);
    check("p1_upd",  64'(bus.update_quota_o), 64'hF);
    check("p1_pcnt", 64'(bus.period_cnt_o), 64'd7);
    step(5);
    check("p1_pcnt6", 64'(bus.period_cnt_o), 64'd12);

    // Stop then restart with P=10: fresh LOAD, timer restarts
    bus.stop_i = 1'b1; step(1); bus.stop_i = 1'b0;
    bus.period_i = 32'd10;
    bus.start_i = 1'b1; step(1); bus.start_i = 1'b0;
    check("restart_state", 64'(bus.state_o), 64'd1);
    step(10);
    check("restart_noupd", 64'(bus.update_quota_o), 64'd0);
    step(1);
    check("restart_upd",  64'(bus.update_quota_o), 64'hF);
    check("restart_pcnt", 64'(bus.period_cnt_o), 64'd13);

    // Saturating counter on core 0, P=3
    bus.stop_i = 1'b1; step(1); bus.stop_i = 1'b0;
    bus.period_i = 32'd3;
    bus.start_i = 1'b1; step(2); bus.start_i = 1'b0;
    bus.irq_i[0] = 1'b1; step(14); bus.irq_i[0] = 1'b0;
    check("cnt0_sat", 64'(bus.overrun_cnt_o[0]), 64'd3);
    step(2);

    // Asynchronous reset mid-RUN
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_enable", 64'(bus.mccu_enable_o), 64'd0);
    compare_snap(m);
    @(negedge clk);
    rstn = 1'b1;
    step(3);
    check("post_rst_state", 64'(bus.state_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
